bram_rw_scheduler: RTL and testbench
====================================

Name: bram_rw_scheduler

Overview:
- Shares one single-port BRAM between a burst-read channel and a burst-write channel.
- Latches each channel's start request, arbitrates round-robin and generates sequential BRAM addresses from a captured base/length.
- Reports per-channel idle/run/done status in the same style as the accessor counter FSMs.
- Sits between the accessor clients and the BRAM primitive.

Parameters:
- ADDR_WIDTH, 12, BRAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, BRAM data width.
- CNT_WIDTH, 13, burst length width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_start_i  in  1  read burst request; one-cycle pulse
- rd_base_i  in  ADDR_WIDTH  read start address; captured with rd_start_i
- rd_len_i  in  CNT_WIDTH  read beat count; captured with rd_start_i
- rd_data_o  out  DATA_WIDTH  read data; qualified by rd_valid_o
- rd_valid_o  out  1  read beat valid
- rd_idle_o / rd_run_o / rd_done_o  out  1 each  read channel status
- wr_start_i  in  1  write burst request
- wr_base_i  in  ADDR_WIDTH  write start address; captured with wr_start_i
- wr_len_i  in  CNT_WIDTH  write beat count; captured with wr_start_i
- wr_data_i  in  DATA_WIDTH  write data
- wr_valid_i  in  1  write beat offered
- wr_ready_o  out  1  write beat accepted when wr_valid_i & wr_ready_o
- wr_idle_o / wr_run_o / wr_done_o  out  1 each  write channel status
- bram_addr_o  out  ADDR_WIDTH  BRAM address
- bram_ce_o  out  1  BRAM enable
- bram_we_o  out  1  BRAM write enable
- bram_d_o  out  DATA_WIDTH  BRAM write data
- bram_q_i  in  DATA_WIDTH  BRAM read data, one cycle after the address

Behaviour:
- Reset: FSM=IDLE; pending flags, counters, captured base/len cleared; last_grant=WR so read wins the first tie.
- Reset outputs: all outputs 0 except rd_idle_o=wr_idle_o=1.
- Reset asserted mid-burst aborts the burst: no done pulse, no further BRAM access.
- Request capture:
  - x_start_i with x_len_i!=0 while channel x is idle captures base/len and sets pend_x.
  - Start while the channel is pending/run/done is ignored; start with len=0 is ignored.
- Arbitration:
  - The request is x_start_i | pend_x, evaluated only in FSM state IDLE.
  - Only one requester: grant it. Both: grant the one not equal to last_grant.
  - On grant: clear pend, set last_grant, zero the beat counter, enter RD or WR next cycle.
- FSM states: IDLE, RD, RD_DRAIN, WR, DONE.
- RD state:
  - bram_ce_o=1, bram_we_o=0, bram_addr_o=base+cnt; cnt increments every cycle.
  - At cnt==len-1, go to RD_DRAIN.
  - rd_valid_o is bram_ce_o&~bram_we_o delayed one cycle; rd_data_o=bram_q_i while valid, else 0.
  - RD_DRAIN lasts one cycle (last beat valid), then DONE.
- WR state:
  - wr_ready_o=1.
  - On each handshake: bram_ce_o=bram_we_o=1, bram_addr_o=base+cnt, bram_d_o=wr_data_i, cnt++.
  - The handshake with cnt==len-1 goes to DONE. wr_valid_i may idle indefinitely; no timeout.
- DONE: x_done_o=1 for exactly one cycle for the owning channel, then IDLE.
- Outside an access: bram_ce_o=bram_we_o=0, bram_addr_o=0, bram_d_o=0.
- Status:
  - x_run_o=1 while x is pending or owns RD/RD_DRAIN/WR.
  - x_done_o=1 only in DONE for owner x.
  - x_idle_o = ~run & ~done. Exactly one of the three is high per channel.
- Read latency: rd_start_i in cycle T (bus idle) gives addresses T+1..T+N, valid T+2..T+N+1, rd_done_o at T+N+2.
- Write latency: wr_done_o is the cycle after the last handshake.
- Address arithmetic: base+cnt truncated to ADDR_WIDTH, wrapping past the top address.
- Read data order always equals address order.

Optional Feature:
- BRAM_RD_PIPE_EN defined: BRAM output register is in use, so read latency is 2.
  - rd_valid_o is ce&~we delayed two cycles.
  - RD_DRAIN lasts two cycles; rd_done_o at T+N+3.
- Undefined: latency 1 as above.

Test Plan:
- Read, BRAM preloaded mem[k]=k+0x100: rd_start_i base=0x010 len=4 at T -> addr 0x010..0x013 at T+1..T+4; rd_valid_o T+2..T+5 with data 0x110..0x113; rd_done_o pulse T+6; rd_idle_o at T+7.
- Write with gaps: base=0x020 len=3, wr_valid_i toggling 1,0,1,1 -> exactly 3 writes to 0x020..0x022; wr_done_o the cycle after the 3rd handshake.
- Simultaneous starts out of reset (read len=2, write len=2) -> read served first, write starts the cycle after rd_done_o. Repeat both -> write served first (round-robin).
- Wrap: read base=0xFFE len=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Ignored requests: len=0 start -> idle stays 1, no BRAM access. Second rd_start_i during an active read -> ignored; no extra done pulse.
- Reset mid-burst: rst_n low at beat 2 of len=8 write -> all outputs at reset values immediately; no wr_done_o; next fresh burst completes normally.

Source files
------------

// File: rtl/bram_rw_scheduler.sv
// Round-robin scheduler sharing one single-port BRAM between a burst-read and a burst-write channel.
// Define BRAM_RD_PIPE_EN when the BRAM output register is enabled (read latency 2 instead of 1).
module bram_rw_scheduler #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_start_i,
    input  logic [ADDR_WIDTH-1:0] rd_base_i,
    input  logic [CNT_WIDTH-1:0]  rd_len_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_idle_o,
    output logic                  rd_run_o,
    output logic                  rd_done_o,
    input  logic                  wr_start_i,
    input  logic [ADDR_WIDTH-1:0] wr_base_i,
    input  logic [CNT_WIDTH-1:0]  wr_len_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    output logic                  wr_idle_o,
    output logic                  wr_run_o,
    output logic                  wr_done_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic                  bram_ce_o,
    output logic                  bram_we_o,
    output logic [DATA_WIDTH-1:0] bram_d_o,
    input  logic [DATA_WIDTH-1:0] bram_q_i
);

`ifdef BRAM_RD_PIPE_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(RD_LAT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_DRAIN, S_WR, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  rd_pend, wr_pend;
    logic                  last_wr;
    logic [ADDR_WIDTH-1:0] rd_base_q, wr_base_q;
    logic [CNT_WIDTH-1:0]  rd_len_q, wr_len_q;
    logic                  grant_rd, grant_wr, cnt_clr, cnt_inc;
    logic                  rd_acc, wr_acc, rd_req, wr_req;
    logic [RD_LAT-1:0]     vld_pipe;

    // A start only counts when the channel is fully idle and the burst is non-empty.
    assign rd_acc = rd_start_i & (rd_len_i != '0) & rd_idle_o;
    assign wr_acc = wr_start_i & (wr_len_i != '0) & wr_idle_o;
    assign rd_req = rd_acc | rd_pend;
    assign wr_req = wr_acc | wr_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        wr_ready_o  = 1'b0;
        bram_ce_o   = 1'b0;
        bram_we_o   = 1'b0;
        bram_addr_o = '0;
        bram_d_o    = '0;
        case (state)
            S_IDLE: begin
                if (rd_req && (!wr_req || last_wr)) begin
                    grant_rd  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = S_RD;
                end else if (wr_req) begin
                    grant_wr  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = S_WR;
                end
            end
            S_RD: begin
                bram_ce_o   = 1'b1;
                bram_addr_o = rd_base_q + ADDR_WIDTH'(cnt);
                if (cnt == rd_len_q - CNT_ONE) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_RD_DRAIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_RD_DRAIN: begin
                // cnt is reused to time the drain of the read pipeline
                if (cnt == DRAIN_LAST) state_nxt = S_DONE;
                else                   cnt_inc   = 1'b1;
            end
            S_WR: begin
                wr_ready_o = 1'b1;
                if (wr_valid_i) begin
                    bram_ce_o   = 1'b1;
                    bram_we_o   = 1'b1;
                    bram_addr_o = wr_base_q + ADDR_WIDTH'(cnt);
                    bram_d_o    = wr_data_i;
                    if (cnt == wr_len_q - CNT_ONE) state_nxt = S_DONE;
                    else                           cnt_inc   = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend   <= 1'b0;
            wr_pend   <= 1'b0;
            last_wr   <= 1'b1;
            cnt       <= '0;
            rd_base_q <= '0;
            rd_len_q  <= '0;
            wr_base_q <= '0;
            wr_len_q  <= '0;
            vld_pipe  <= '0;
        end else begin
            if (rd_acc) begin
                rd_base_q <= rd_base_i;
                rd_len_q  <= rd_len_i;
            end
            if (wr_acc) begin
                wr_base_q <= wr_base_i;
                wr_len_q  <= wr_len_i;
            end
            if (grant_rd)    rd_pend <= 1'b0;
            else if (rd_acc) rd_pend <= 1'b1;
            if (grant_wr)    wr_pend <= 1'b0;
            else if (wr_acc) wr_pend <= 1'b1;
            if (grant_rd)      last_wr <= 1'b0;
            else if (grant_wr) last_wr <= 1'b1;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CNT_ONE;
            vld_pipe[0] <= bram_ce_o & ~bram_we_o;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign rd_valid_o = vld_pipe[RD_LAT-1];
    assign rd_data_o  = rd_valid_o ? bram_q_i : '0;

    // DONE always belongs to the most recent grant.
    assign rd_run_o  = rd_pend | (state == S_RD) | (state == S_RD_DRAIN);
    assign wr_run_o  = wr_pend | (state == S_WR);
    assign rd_done_o = (state == S_DONE) & ~last_wr;
    assign wr_done_o = (state == S_DONE) & last_wr;
    assign rd_idle_o = ~rd_run_o & ~rd_done_o;
    assign wr_idle_o = ~wr_run_o & ~wr_done_o;

endmodule

// File: tb/tb_bram_rw_scheduler.sv
// Directed bench for bram_rw_scheduler: read table plus hand-written write/arbitration/reset sequences.
module tb_bram_rw_scheduler;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_start, wr_start, wr_valid;
    logic [AW-1:0] rd_base, wr_base;
    logic [CW-1:0] rd_len, wr_len;
    logic [DW-1:0] rd_data, wr_data, bram_d, bram_q;
    logic          rd_valid, rd_idle, rd_run, rd_done;
    logic          wr_ready, wr_idle, wr_run, wr_done;
    logic [AW-1:0] bram_addr;
    logic          bram_ce, bram_we;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            nwrites = 0;
    int            checks  = 0;
    int            errors  = 0;

    always #5 clk = ~clk;

    bram_rw_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_start_i(rd_start), .rd_base_i(rd_base), .rd_len_i(rd_len),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .rd_idle_o(rd_idle), .rd_run_o(rd_run), .rd_done_o(rd_done),
        .wr_start_i(wr_start), .wr_base_i(wr_base), .wr_len_i(wr_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_idle_o(wr_idle), .wr_run_o(wr_run), .wr_done_o(wr_done),
        .bram_addr_o(bram_addr), .bram_ce_o(bram_ce), .bram_we_o(bram_we),
        .bram_d_o(bram_d), .bram_q_i(bram_q)
    );

    // Single-port BRAM, one-cycle read latency.
    always @(posedge clk) begin
        if (bram_ce) begin
            if (bram_we) begin
                mem[bram_addr] <= bram_d;
                nwrites        <= nwrites + 1;
            end else begin
                bram_q <= mem[bram_addr];
            end
        end
    end

    typedef struct {
        logic          rs;
        logic [AW-1:0] rb;
        logic [CW-1:0] rl;
        logic          ce;
        logic [AW-1:0] addr;
        logic          vld;
        logic [DW-1:0] data;
        logic [2:0]    st;     // {idle, run, done} of the read channel
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_data"}, 64'(rd_data), 64'h0);
        chk({tag, "_bram_d"}, 64'(bram_d), 64'h0);
        chk({tag, "_addr"}, 64'(bram_addr), 64'h0);
        chk({tag, "_flags"},
            64'({rd_valid, rd_idle, rd_run, rd_done, wr_ready, wr_idle, wr_run, wr_done, bram_ce, bram_we}),
            64'(10'b01_0001_0000));
    endtask

    task automatic add(input logic rs, input logic [AW-1:0] rb, input logic [CW-1:0] rl,
                       input logic ce, input logic [AW-1:0] addr, input logic vld,
                       input logic [DW-1:0] data, input logic [2:0] st);
        vec_t v;
        v.rs = rs; v.rb = rb; v.rl = rl; v.ce = ce; v.addr = addr;
        v.vld = vld; v.data = data; v.st = st;
        tv.push_back(v);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < (1 << AW); k++) mem[k] = DW'(k + 32'h100);
        bram_q   = '0;
        rst_n    = 1'b0;
        rd_start = 0; rd_base = '0; rd_len = '0;
        wr_start = 0; wr_base = '0; wr_len = '0; wr_valid = 0; wr_data = '0;

        // read base 0x010 len 4; a second start in the middle is ignored
        add(1, 12'h010, 13'd4, 0, 12'h000, 0, 32'h0,   3'b100);
        add(0, 12'h000, 13'd0, 1, 12'h010, 0, 32'h0,   3'b010);
        add(1, 12'h300, 13'd5, 1, 12'h011, 1, 32'h110, 3'b010);
        add(0, 12'h000, 13'd0, 1, 12'h012, 1, 32'h111, 3'b010);
        add(0, 12'h000, 13'd0, 1, 12'h013, 1, 32'h112, 3'b010);
        add(0, 12'h000, 13'd0, 0, 12'h000, 1, 32'h113, 3'b010);
        add(0, 12'h000, 13'd0, 0, 12'h000, 0, 32'h0,   3'b001);
        add(0, 12'h000, 13'd0, 0, 12'h000, 0, 32'h0,   3'b100);
        add(0, 12'h000, 13'd0, 0, 12'h000, 0, 32'h0,   3'b100);
        // len 0 start is ignored
        add(1, 12'h080, 13'd0, 0, 12'h000, 0, 32'h0,   3'b100);
        add(0, 12'h000, 13'd0, 0, 12'h000, 0, 32'h0,   3'b100);
        // address wrap
        add(1, 12'hFFE, 13'd4, 0, 12'h000, 0, 32'h0,    3'b100);
        add(0, 12'h000, 13'd0, 1, 12'hFFE, 0, 32'h0,    3'b010);
        add(0, 12'h000, 13'd0, 1, 12'hFFF, 1, 32'h10FE, 3'b010);
        add(0, 12'h000, 13'd0, 1, 12'h000, 1, 32'h10FF, 3'b010);
        add(0, 12'h000, 13'd0, 1, 12'h001, 1, 32'h100,  3'b010);
        add(0, 12'h000, 13'd0, 0, 12'h000, 1, 32'h101,  3'b010);
        add(0, 12'h000, 13'd0, 0, 12'h000, 0, 32'h0,    3'b001);
        add(0, 12'h000, 13'd0, 0, 12'h000, 0, 32'h0,    3'b100);

        #1;
        chk_reset_outputs("reset");
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();

        foreach (tv[i]) begin
            cyc();
            rd_start = tv[i].rs; rd_base = tv[i].rb; rd_len = tv[i].rl;
            #1;
            chk($sformatf("row%0d_ce", i),   64'(bram_ce),   64'(tv[i].ce));
            chk($sformatf("row%0d_we", i),   64'(bram_we),   64'h0);
            chk($sformatf("row%0d_addr", i), 64'(bram_addr), 64'(tv[i].addr));
            chk($sformatf("row%0d_vld", i),  64'(rd_valid),  64'(tv[i].vld));
            chk($sformatf("row%0d_data", i), 64'(rd_data),   64'(tv[i].data));
            chk($sformatf("row%0d_st", i),   64'({rd_idle, rd_run, rd_done}), 64'(tv[i].st));
        end
        cyc(); rd_start = 0;

        // write base 0x020 len 3 with a gap in wr_valid
        begin
            int w0;
            w0 = nwrites;
            cyc(); wr_start = 1; wr_base = 12'h020; wr_len = 13'd3; #1;
            chk("wg_idle0", 64'(wr_idle), 64'h1);
            cyc(); wr_start = 0; wr_valid = 1; wr_data = 32'hA000_0001; #1;
            chk("wg_b0", 64'({wr_ready, wr_run, bram_ce, bram_we, bram_addr}), 64'({4'b1111, 12'h020}));
            chk("wg_d0", 64'(bram_d), 64'hA000_0001);
            cyc(); wr_valid = 0; wr_data = 32'hA000_0002; #1;
            chk("wg_gap", 64'({wr_ready, bram_ce, bram_we}), 64'(3'b100));
            cyc(); wr_valid = 1; wr_data = 32'hA000_0003; #1;
            chk("wg_b1", 64'({bram_ce, bram_we, bram_addr}), 64'({2'b11, 12'h021}));
            cyc(); wr_data = 32'hA000_0004; #1;
            chk("wg_b2", 64'({bram_ce, bram_we, bram_addr}), 64'({2'b11, 12'h022}));
            cyc(); wr_valid = 0; #1;
            chk("wg_done", 64'({wr_done, wr_ready, bram_ce}), 64'(3'b100));
            cyc(); #1;
            chk("wg_idle", 64'({wr_idle, wr_run, wr_done}), 64'(3'b100));
            chk("wg_nwrites", 64'(nwrites - w0), 64'd3);
            chk("wg_mem20", 64'(mem[12'h020]), 64'hA000_0001);
            chk("wg_mem21", 64'(mem[12'h021]), 64'hA000_0003);
            chk("wg_mem22", 64'(mem[12'h022]), 64'hA000_0004);
            chk("wg_mem23", 64'(mem[12'h023]), 64'h123);
        end

        // write start with len 0 is ignored
        cyc(); wr_start = 1; wr_base = 12'h030; wr_len = 13'd0; wr_valid = 1;
        cyc(); wr_start = 0; #1;
        chk("wlen0", 64'({wr_idle, wr_run, wr_done, wr_ready, bram_ce}), 64'(5'b10000));
        wr_valid = 0;

        // simultaneous starts out of reset: read first
        cyc(); rst_n = 0;
        cyc(); rst_n = 1;
        cyc();
        rd_start = 1; rd_base = 12'h040; rd_len = 13'd2;
        wr_start = 1; wr_base = 12'h050; wr_len = 13'd2; wr_valid = 1; wr_data = 32'hB000_0000;
        cyc(); rd_start = 0; wr_start = 0; #1;
        chk("sim_rd0", 64'({bram_ce, bram_we, bram_addr, wr_ready, wr_run}), 64'({2'b10, 12'h040, 2'b01}));
        cyc(); #1;
        chk("sim_rd1", 64'(bram_addr), 64'h041);
        cyc(); #1;
        chk("sim_drain", 64'({rd_valid, rd_data}), 64'({1'b1, 32'h141}));
        cyc(); #1;
        chk("sim_rddone", 64'({rd_done, wr_ready}), 64'(2'b10));
        cyc(); #1;
        chk("sim_gap", 64'({wr_ready, wr_run, rd_idle}), 64'(3'b011));
        cyc(); wr_data = 32'hB000_0001; #1;
        chk("sim_wr0", 64'({wr_ready, bram_ce, bram_we, bram_addr}), 64'({3'b111, 12'h050}));
        cyc(); wr_data = 32'hB000_0002; #1;
        chk("sim_wr1", 64'(bram_addr), 64'h051);
        cyc(); wr_valid = 0; #1;
        chk("sim_wrdone", 64'(wr_done), 64'h1);

        // lone read, then a tie: the write wins this time
        cyc(); rd_start = 1; rd_base = 12'h060; rd_len = 13'd1;
        cyc(); rd_start = 0;
        cyc(); cyc(); #1;
        chk("solo_done", 64'(rd_done), 64'h1);
        cyc();
        rd_start = 1; rd_base = 12'h070; rd_len = 13'd1;
        wr_start = 1; wr_base = 12'h058; wr_len = 13'd1; wr_data = 32'hC000_0000;
        cyc(); rd_start = 0; wr_start = 0; #1;
        chk("rr_wrfirst", 64'({wr_ready, rd_run, bram_ce}), 64'(3'b110));
        cyc(); wr_valid = 1; #1;
        chk("rr_wrbeat", 64'({bram_ce, bram_we, bram_addr}), 64'({2'b11, 12'h058}));
        cyc(); wr_valid = 0; #1;
        chk("rr_wrdone", 64'(wr_done), 64'h1);
        cyc(); cyc(); #1;
        chk("rr_rdbeat", 64'({bram_ce, bram_we, bram_addr}), 64'({2'b10, 12'h070}));
        cyc(); cyc(); #1;
        chk("rr_rddone", 64'(rd_done), 64'h1);

        // reset in the middle of a len 8 write
        cyc(); wr_start = 1; wr_base = 12'h100; wr_len = 13'd8; wr_valid = 1; wr_data = 32'hE000_0000;
        cyc(); wr_start = 0;
        cyc();
        cyc(); rst_n = 0; #1;
        chk_reset_outputs("midrst");
        cyc(); rst_n = 1; wr_valid = 0;
        begin
            int ndone, nce;
            ndone = 0; nce = 0;
            for (int k = 0; k < 4; k++) begin
                cyc(); #1;
                if (wr_done) ndone++;
                if (bram_ce) nce++;
            end
            chk("midrst_nodone", 64'(ndone), 64'h0);
            chk("midrst_noaccess", 64'(nce), 64'h0);
        end
        chk("midrst_mem102", 64'(mem[12'h102]), 64'h202);
        cyc(); wr_start = 1; wr_base = 12'h200; wr_len = 13'd2; wr_valid = 1;
        cyc(); wr_start = 0; wr_data = 32'hD000_0000;
        cyc(); wr_data = 32'hD000_0001;
        cyc(); wr_valid = 0; #1;
        chk("fresh_done", 64'(wr_done), 64'h1);
        chk("fresh_mem200", 64'(mem[12'h200]), 64'hD000_0000);
        chk("fresh_mem201", 64'(mem[12'h201]), 64'hD000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
